// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg
//   Definitions shared between the PWM capture block and the servo PWM
//   generator: FSM state encoding, default tick rate, duty code width and
//   nominal period length, plus the duty-code helper.
package pwm_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   localparam int unsigned DEF_TICK_HZ  = 100;
   localparam int unsigned DUTY_W       = 4;
   localparam int unsigned PERIOD_TICKS = 100;
   localparam int unsigned DUTY_MAX     = (2 ** DUTY_W) - 1;

   // Clamp a tick count to the generator's duty code range.
   function automatic logic [DUTY_W-1:0] duty_code(input logic [31:0] ticks);
      if (ticks > DUTY_MAX)
         return '1;
      else
         return ticks[DUTY_W-1:0];
   endfunction

endpackage

// File: rtl/pwm_tick_div.sv
// pwm_tick_div
//   Free-running prescaler 0..DIV-1 with synchronous clear.
//   Ports:
//     clk    in        system clock
//     rst_n  in        asynchronous active-low reset
//     clr    in        synchronous clear of the prescaler
//     presc  out [PW]  current prescaler count
//     tick   out       high while presc is at DIV-1 (wraps on next edge)
module pwm_tick_div #(
   parameter int unsigned DIV = 10,
   parameter int unsigned PW  = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   output logic [PW-1:0] presc,
   output logic          tick
);

   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   assign tick = (presc == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         presc <= '0;
      else if (clr || tick)
         presc <= '0;
      else
         presc <= presc + PW'(1);
   end

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures an incoming PWM waveform: high time and rise-to-rise period in
//   ticks (rounded), plus a 4-bit duty code compatible with the generator.
//   Ports:
//     clk           in        system clock
//     rst_n         in        asynchronous active-low reset
//     pwm_in        in        asynchronous PWM pin
//     high_ticks    out [CW]  last measured high time
//     period_ticks  out [CW]  last measured period
//     duty          out [4]   min(high_ticks, 15)
//     valid         out       one-clock pulse when a measurement is latched
//     timeout       out       no edge within MAX_TICKS; cleared by next valid
//     level         out       synchronized pwm_in
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 50_000_000,
   parameter int unsigned TICK_HZ   = DEF_TICK_HZ,
   parameter int unsigned CW        = 7,
   parameter int unsigned MAX_TICKS = 127
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pwm_in,
   output logic [CW-1:0]     high_ticks,
   output logic [CW-1:0]     period_ticks,
   output logic [DUTY_W-1:0] duty,
   output logic              valid,
   output logic              timeout,
   output logic              level
);

   localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
   localparam int unsigned PW    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned HALF  = DIV / 2;
   localparam logic [CW-1:0] MAX_C = CW'(MAX_TICKS);

   // ---------------- synchronizer and edge detect ----------------
   logic       meta, sync, prev;
   logic [2:0] fill;
   logic       primed, rise, fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
         fill <= '0;
      end else begin
         meta <= pwm_in;
         sync <= meta;
         prev <= sync;
         fill <= {fill[1:0], 1'b1};
      end
   end

   // Edges are only trusted once prev holds a real pin sample (three clocks
   // after reset); otherwise a pin already high at reset exit would look
   // like a rise against the cleared flops.
   assign primed = fill[2];
   assign rise   = primed &  sync & ~prev;
   assign fall   = primed & ~sync &  prev;
   assign level  = sync;

   // ---------------- prescaler and tick counter ----------------
   logic          clr;
   logic [PW-1:0] presc;
   logic          tick;
   logic [CW-1:0] tick_cnt;

   pwm_tick_div #(
      .DIV (DIV),
      .PW  (PW)
   ) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .presc (presc),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tick_cnt <= '0;
      else if (clr)
         tick_cnt <= '0;
      else if (tick && (tick_cnt != MAX_C))
         tick_cnt <= tick_cnt + CW'(1);
   end

   // Rounded elapsed ticks. The clock on which the edge is acted upon is
   // counted, so presc+1 is the number of clocks in the partial tick; when
   // that equals DIV it naturally rounds up to a whole extra tick.
   logic [PW:0]   presc_inc;
   logic          step;
   logic [CW-1:0] r;

   always_comb begin
      presc_inc = {1'b0, presc} + (PW+1)'(1);
      step      = (presc_inc >= (PW+1)'(HALF));
      if (tick_cnt == MAX_C)
         r = MAX_C;
      else
         r = tick_cnt + CW'(step);
   end

   // ---------------- measurement FSM ----------------
   state_t state, state_d;
   logic   hold_en, latch_en, to_set;
   logic   at_max;

   assign at_max = (tick_cnt == MAX_C);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_d;
   end

   always_comb begin
      state_d  = state;
      clr      = 1'b0;
      hold_en  = 1'b0;
      latch_en = 1'b0;
      to_set   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rise) begin
               clr     = 1'b1;
               state_d = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (fall) begin
               hold_en = 1'b1;
               state_d = ST_LOW;
            end else if (at_max) begin
               to_set  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_LOW: begin
            if (rise) begin
               latch_en = 1'b1;
               clr      = 1'b1;
               state_d  = ST_HIGH;
            end else if (at_max) begin
               to_set  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- result registers ----------------
   logic [CW-1:0] high_hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         high_hold    <= '0;
         high_ticks   <= '0;
         period_ticks <= '0;
         duty         <= '0;
         valid        <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         valid <= latch_en;
         if (hold_en)
            high_hold <= r;
         if (latch_en) begin
            high_ticks   <= high_hold;
            period_ticks <= r;
            duty         <= duty_code(32'(high_hold));
            timeout      <= 1'b0;
         end else if (to_set) begin
            timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

   localparam int unsigned CW = 7;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          pwm_in = 1'b0;
   logic [CW-1:0] high_ticks;
   logic [CW-1:0] period_ticks;
   logic [3:0]    duty;
   logic          valid;
   logic          timeout;
   logic          level;

   always #5 clk = ~clk;

   pwm_capture #(
      .CLK_HZ    (1000),
      .TICK_HZ   (100),
      .CW        (CW),
      .MAX_TICKS (127)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pwm_in       (pwm_in),
      .high_ticks   (high_ticks),
      .period_ticks (period_ticks),
      .duty         (duty),
      .valid        (valid),
      .timeout      (timeout),
      .level        (level)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // valid pulse monitor: count pulses, record their cycle, catch long pulses
   int   cyc     = 0;
   int   vcnt    = 0;
   int   vdouble = 0;
   int   vcyc[$];
   logic vprev   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      vprev <= valid;
      if (valid === 1'b1) begin
         vcnt <= vcnt + 1;
         vcyc.push_back(cyc);
         if (vprev === 1'b1) vdouble <= vdouble + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int h, input int l);
      pwm_in = 1'b1;
      wait_clks(h);
      pwm_in = 1'b0;
      wait_clks(l);
   endtask

   task automatic check_out(input string tag, input int h, input int p, input int d);
      check({tag, "_high"},   32'(high_ticks),   32'(h));
      check({tag, "_period"}, 32'(period_ticks), 32'(p));
      check({tag, "_duty"},   32'(duty),         32'(d));
   endtask

   initial begin
      int v0;

      // 1: reset held with a toggling pin
      rst_n = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         pwm_in = ~pwm_in;
      end
      check_out("reset", 0, 0, 0);
      check("reset_valid_cnt", 32'(vcnt), 32'd0);
      check("reset_timeout", 32'(timeout), 32'd0);
      check("reset_level", 32'(level), 32'd0);
      pwm_in = 1'b0;
      wait_clks(2);
      rst_n = 1'b1;
      wait_clks(5);

      // 2: generator-like 3/100 ticks, three full periods closed by a 4th rise
      pulse(30, 970);
      check("first_rise_no_valid", 32'(vcnt), 32'd0);
      pulse(30, 970);
      pulse(30, 970);
      // 3: rise of 24-clk pulse closes third 3/100 period
      pulse(24, 476);
      check("gen_valid_cnt", 32'(vcnt), 32'd3);
      check_out("gen", 3, 100, 3);
      check("gen_interval_1", 32'(vcyc[1] - vcyc[0]), 32'd1000);
      check("gen_interval_2", 32'(vcyc[2] - vcyc[1]), 32'd1000);
      check("gen_timeout", 32'(timeout), 32'd0);

      pulse(25, 475);
      check_out("h24", 2, 50, 2);
      pulse(200, 300);
      check_out("h25", 3, 50, 3);
      pulse(30, 70);
      check_out("h200", 20, 50, 15);

      // 4: rise (closes 30/100 clks) then stuck high 130 ticks
      pwm_in = 1'b1;
      wait_clks(1250);
      check("stuck_timeout_early", 32'(timeout), 32'd0);
      wait_clks(50);
      check("stuck_timeout", 32'(timeout), 32'd1);
      check("stuck_level", 32'(level), 32'd1);
      check_out("stuck_hold", 3, 10, 3);
      v0 = vcnt;
      pwm_in = 1'b0;
      wait_clks(50);
      pulse(30, 970);
      check("recover_still_timeout", 32'(timeout), 32'd1);
      check("recover_no_valid", 32'(vcnt), 32'(v0));
      pwm_in = 1'b1;
      wait_clks(20);
      check("recover_valid_cnt", 32'(vcnt), 32'(v0 + 1));
      check("recover_timeout", 32'(timeout), 32'd0);
      check_out("recover", 3, 100, 3);

      // 5/6: reset mid-HIGH, pin still high at release
      rst_n = 1'b0;
      wait_clks(3);
      check_out("midreset", 0, 0, 0);
      check("midreset_valid", 32'(valid), 32'd0);
      v0 = vcnt;
      rst_n = 1'b1;
      wait_clks(20);
      pwm_in = 1'b0;
      wait_clks(80);
      pulse(50, 450);
      check("after_reset_no_valid", 32'(vcnt), 32'(v0));
      pulse(10, 90);
      check("after_reset_valid_cnt", 32'(vcnt), 32'(v0 + 1));
      check_out("after_reset", 5, 50, 5);
      check("valid_one_clk", 32'(vdouble), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
